// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Brief    : Shared types and default parameter constants for sram_arb.
// Revision : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  // Default configuration constants
  localparam int unsigned C_DATA_W   = 8;
  localparam int unsigned C_ADDR_W   = 13;
  localparam int unsigned C_INIT_VAL = 0;

  // Controller state: sweeping the array to INIT_VAL, or serving requests
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-requester round-robin arbiter. A lone requester is granted
//            immediately; on contention the port not granted most recently
//            wins. After reset port A (req[0]) is favoured.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 when port A received the most recent grant
  logic r_last_a;

  // Grant selection: lone requester wins, contention goes to the other port
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = r_last_a ? 2'b10 : 2'b01;
    end
  end

  // Remember which port was granted last; reset value favours A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_a <= 1'b0;
    end else if (gnt[0]) begin
      r_last_a <= 1'b1;
    end else if (gnt[1]) begin
      r_last_a <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb
// Brief    : Single-port SRAM shared by two requesters through a round-robin
//            arbiter, with a hardware clear sweep after reset or on clr.
//            Optional macro SRAM_ARB_PARITY_EN adds an even-parity bit per
//            word and a perr pulse on read mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int unsigned         DATA_W   = C_DATA_W,
  parameter int unsigned         ADDR_W   = C_ADDR_W,
  parameter logic [DATA_W-1:0]   INIT_VAL = DATA_W'(C_INIT_VAL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              perr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;
`ifdef SRAM_ARB_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [MEM_W-1:0]    r_mem [DEPTH];

  logic                r_a_rvalid;
  logic                r_b_rvalid;
  logic [DATA_W-1:0]   r_a_rdata;
  logic [DATA_W-1:0]   r_b_rdata;

  logic                w_run;
  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_we;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_wr_en;
  logic                w_rd_en;
  logic [MEM_W-1:0]    w_wr_word;
  logic [MEM_W-1:0]    w_init_word;
  logic [MEM_W-1:0]    w_rd_word;

  // Requests only reach the arbiter in RUN, and not in the cycle clr arrives
  assign w_run = (r_state == RUN) && !clr;
  assign w_req = {b_req, a_req} & {2{w_run}};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_req),
    .gnt   (w_gnt)
  );

  assign a_gnt = w_gnt[0];
  assign b_gnt = w_gnt[1];
  assign busy  = (r_state == CLEAR);

  // The single array port is steered by whichever requester holds the grant
  assign w_addr    = w_gnt[1] ? b_addr  : a_addr;
  assign w_we      = w_gnt[1] ? b_we    : a_we;
  assign w_wdata   = w_gnt[1] ? b_wdata : a_wdata;
  assign w_wr_en   = (|w_gnt) &  w_we;
  assign w_rd_en   = (|w_gnt) & ~w_we;
  assign w_rd_word = r_mem[w_addr];

`ifdef SRAM_ARB_PARITY_EN
  assign w_wr_word   = {^w_wdata,  w_wdata};
  assign w_init_word = {^INIT_VAL, INIT_VAL};
`else
  assign w_wr_word   = w_wdata;
  assign w_init_word = INIT_VAL;
`endif

  // Controller: sweep every address once, then serve requests until clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == C_LAST_ADDR) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (clr) begin
            r_state <= CLEAR;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  // Array write port: sweep data has priority since no grants exist in CLEAR
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_cnt] <= w_init_word;
    end else if (w_wr_en) begin
      r_mem[w_addr] <= w_wr_word;
    end
  end

  // Read return path: data lands one cycle after the grant and then holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= w_rd_en & w_gnt[0];
      r_b_rvalid <= w_rd_en & w_gnt[1];
      if (w_rd_en && w_gnt[0]) begin
        r_a_rdata <= w_rd_word[DATA_W-1:0];
      end
      if (w_rd_en && w_gnt[1]) begin
        r_b_rdata <= w_rd_word[DATA_W-1:0];
      end
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

`ifdef SRAM_ARB_PARITY_EN
  logic r_perr;

  // Parity check: stored word including its parity bit must have even weight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_rd_en & (^w_rd_word);
    end
  end

  assign perr = r_perr;
`else
  assign perr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_arb
// Brief    : Self-checking bench for sram_arb with a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arb;

  localparam int DW    = 8;
  localparam int AW    = 13;
  localparam int DEPTH = 8192;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr   = 1'b0;
  logic          busy;
  logic          a_req = 1'b0, a_we = 1'b0, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0, a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0, b_rdata;
  logic          perr;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW:0]   exp_a [$];
  logic [DW:0]   exp_b [$];
  logic [DW:0]   mon_e;

  sram_arb #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .perr(perr)
  );

  always #5 clk = ~clk;

  // Scoreboard: every rvalid pops the oldest expected {perr, data} of its port
  always @(negedge clk) begin
    if (a_rvalid === 1'b1) begin
      checks++;
      if (exp_a.size() == 0) begin
        failures++;
        $display("FAIL a_rvalid_unexpected: got rdata=%h perr=%b, no read pending", a_rdata, perr);
      end else begin
        mon_e = exp_a.pop_front();
        if ({perr, a_rdata} !== mon_e) begin
          failures++;
          $display("FAIL a_read_data: got perr=%b rdata=%h, expected perr=%b rdata=%h",
                   perr, a_rdata, mon_e[DW], mon_e[DW-1:0]);
        end
      end
    end
    if (b_rvalid === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        failures++;
        $display("FAIL b_rvalid_unexpected: got rdata=%h perr=%b, no read pending", b_rdata, perr);
      end else begin
        mon_e = exp_b.pop_front();
        if ({perr, b_rdata} !== mon_e) begin
          failures++;
          $display("FAIL b_read_data: got perr=%b rdata=%h, expected perr=%b rdata=%h",
                   perr, b_rdata, mon_e[DW], mon_e[DW-1:0]);
        end
      end
    end
  end

  // Apply both ports' inputs (from just after a rising edge) and wait to the falling edge
  task automatic drive(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 13'd0, 8'h00, 1'b1, 1'b0, 13'd1, 8'h00);
    @(negedge clk);
    checks++;
    if ({busy, a_gnt, b_gnt, a_rvalid, b_rvalid, perr, a_rdata, b_rdata} !== {6'b100000, 16'h0000}) begin
      failures++;
      $display("FAIL reset_state: got busy=%b gnt=%b%b rvalid=%b%b perr=%b rdata=%h/%h, expected busy=1 rest 0",
               busy, a_gnt, b_gnt, a_rvalid, b_rvalid, perr, a_rdata, b_rdata);
    end
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    int n;
    bit saw_gnt;
    n = 0;
    saw_gnt = 1'b0;
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    @(negedge clk);
    while (busy === 1'b1 && n < 9000) begin
      n++;
      if (a_gnt !== 1'b0 || b_gnt !== 1'b0) saw_gnt = 1'b1;
      if (n == 100) clr = 1'b1;
      if (n == 101) clr = 1'b0;
      if (n == 8000) begin a_req = 1'b0; b_req = 1'b0; end
      @(negedge clk);
    end
    checks++;
    if (n != 8192) begin
      failures++;
      $display("FAIL sweep_length: busy high for %0d cycles, expected 8192", n);
    end
    checks++;
    if (saw_gnt) begin
      failures++;
      $display("FAIL sweep_no_grant: grant seen during sweep, expected none");
    end
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    step();
  endtask

  task automatic test_readback();
    int gerr;
    gerr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b1, 1'b0, AW'(i), 8'h00);
      if (b_gnt !== 1'b1 || a_gnt !== 1'b0) gerr++;
      exp_b.push_back({1'b0, model[i]});
      step();
    end
    drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    step();
    checks++;
    if (gerr != 0) begin
      failures++;
      $display("FAIL readback_grants: %0d cycles without sole B grant, expected 0", gerr);
    end
    checks++;
    if (exp_b.size() != 0) begin
      failures++;
      $display("FAIL readback_lost: %0d reads pending, expected 0", exp_b.size());
    end
  endtask

  task automatic test_contention();
    drive(1'b1, 1'b1, 13'd1, 8'hAA, 1'b1, 1'b0, 13'd1, 8'h00);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL contention_first: got a_gnt=%b b_gnt=%b, expected 1 0", a_gnt, b_gnt);
    end
    model[1] = 8'hAA;
    step();
    drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b1, 1'b0, 13'd1, 8'h00);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL contention_second: got a_gnt=%b b_gnt=%b, expected 0 1", a_gnt, b_gnt);
    end
    exp_b.push_back({1'b0, model[1]});
    step();
    drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 8'hAA) begin
      failures++;
      $display("FAIL contention_read: got b_rvalid=%b b_rdata=%h, expected 1 aa", b_rvalid, b_rdata);
    end
    step();
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 13'd0, 8'hFF, 1'b0, 1'b0, 13'd0, 8'h00);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL wr_grant: got a_gnt=%b b_gnt=%b, expected 1 0", a_gnt, b_gnt);
    end
    model[0] = 8'hFF;
    step();
    drive(1'b1, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    checks++;
    if (a_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rd_grant: got a_gnt=%b, expected 1", a_gnt);
    end
    exp_a.push_back({1'b0, model[0]});
    step();
    drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 8'hFF) begin
      failures++;
      $display("FAIL rd_latency: got a_rvalid=%b a_rdata=%h, expected 1 ff", a_rvalid, a_rdata);
    end
    step();
    drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 8'hFF) begin
      failures++;
      $display("FAIL rdata_hold: got a_rvalid=%b a_rdata=%h, expected 0 ff", a_rvalid, a_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int ka, kb, na, nb, alt_err;
    logic [DW-1:0] wd;
    // A lone B read leaves B as the most recent grant, so contention starts with A
    drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b1, 1'b0, 13'd0, 8'h00);
    exp_b.push_back({1'b0, model[0]});
    step();
    ka = 0; kb = 0; na = 0; nb = 0; alt_err = 0;
    for (int c = 0; c < 10; c++) begin
      wd = 8'h30 + 8'(ka);
      drive(1'b1, 1'b1, AW'(32 + ka), wd, 1'b1, 1'b0, AW'(32 + kb), 8'h00);
      na += int'(a_gnt === 1'b1);
      nb += int'(b_gnt === 1'b1);
      if ((c % 2) == 0) begin
        if ({a_gnt, b_gnt} !== 2'b10) alt_err++;
        model[32 + ka] = wd;
        ka++;
      end else begin
        if ({a_gnt, b_gnt} !== 2'b01) alt_err++;
        exp_b.push_back({1'b0, model[32 + kb]});
        kb++;
      end
      step();
    end
    drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    step();
    checks++;
    if (alt_err != 0) begin
      failures++;
      $display("FAIL b2b_alternate: %0d cycles out of order, expected 0", alt_err);
    end
    checks++;
    if (na != 5 || nb != 5) begin
      failures++;
      $display("FAIL b2b_counts: got A=%0d B=%0d grants, expected 5 and 5", na, nb);
    end
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      failures++;
      $display("FAIL b2b_lost: pending A=%0d B=%0d, expected 0 and 0", exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_clr_reset();
    int n;
    drive(1'b1, 1'b0, 13'd32, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    exp_a.push_back({1'b0, model[32]});
    step();
    clr = 1'b1;
    drive(1'b1, 1'b0, 13'd33, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      failures++;
      $display("FAIL clr_no_grant: got a_gnt=%b b_gnt=%b, expected 0 0", a_gnt, b_gnt);
    end
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 8'h30) begin
      failures++;
      $display("FAIL clr_inflight: got a_rvalid=%b a_rdata=%h, expected 1 30", a_rvalid, a_rdata);
    end
    step();
    clr = 1'b0;
    drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL clr_busy: got busy=%b, expected 1", busy);
    end
    for (int i = 0; i < 100; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || a_rdata !== 8'h00 || a_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b a_rdata=%h a_rvalid=%b, expected 1 00 0", busy, a_rdata, a_rvalid);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 9000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 8192) begin
      failures++;
      $display("FAIL resweep_length: busy high for %0d cycles, expected 8192", n);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    step();
    drive(1'b1, 1'b0, 13'd32, 8'h00, 1'b1, 1'b0, 13'd33, 8'h00);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL reset_rr_favours_a: got a_gnt=%b b_gnt=%b, expected 1 0", a_gnt, b_gnt);
    end
    exp_a.push_back({1'b0, model[32]});
    step();
    drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b1, 1'b0, 13'd33, 8'h00);
    exp_b.push_back({1'b0, model[33]});
    step();
    drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    step();
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      failures++;
      $display("FAIL resweep_lost: pending A=%0d B=%0d, expected 0 and 0", exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_parity();
    logic exp_perr;
    drive(1'b1, 1'b1, 13'd5, 8'h5A, 1'b0, 1'b0, 13'd0, 8'h00);
    model[5] = 8'h5A;
    step();
`ifdef SRAM_ARB_PARITY_EN
    dut.r_mem[5][0] = ~dut.r_mem[5][0];
    model[5] = 8'h5B;
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    drive(1'b1, 1'b0, 13'd5, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    exp_a.push_back({exp_perr, model[5]});
    step();
    drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    checks++;
    if (a_rvalid !== 1'b1 || perr !== exp_perr) begin
      failures++;
      $display("FAIL parity_perr: got a_rvalid=%b perr=%b, expected 1 %b", a_rvalid, perr, exp_perr);
    end
    step();
    drive(1'b0, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 13'd0, 8'h00);
    checks++;
    if (perr !== 1'b0) begin
      failures++;
      $display("FAIL parity_pulse: got perr=%b one cycle later, expected 0", perr);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_readback();
    test_contention();
    test_write_read();
    test_back_to_back();
    test_clr_reset();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits.
REQ-002 Parameter ADDR_W, default 13: address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter INIT_VAL, default 0, DATA_W bits: value written to every word by a clear sweep.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  system clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 clr  in  1  single-cycle pulse requesting a clear sweep.
REQ-008 busy  out  1  high while a clear sweep runs.
REQ-009 a_req, b_req  in  1  per-port access request, held until granted.
REQ-010 a_we, b_we  in  1  1 = write, 0 = read (qualified by req).
REQ-011 a_addr, b_addr  in  ADDR_W  word address.
REQ-012 a_wdata, b_wdata  in  DATA_W  write data.
REQ-013 a_gnt, b_gnt  out  1  combinational grant; the access executes on this clock edge.
REQ-014 a_rvalid, b_rvalid  out  1  one-cycle pulse, read data valid.
REQ-015 a_rdata, b_rdata  out  DATA_W  registered read data.
REQ-016 perr  out  1  one-cycle pulse, read parity mismatch (see Configuration).

Function
REQ-017 Storage SHALL be a single-port array of DEPTH words; at most one access per cycle.
REQ-018 FSM states SHALL be CLEAR and RUN only.
REQ-019 In CLEAR: one word per cycle at counter addresses 0..DEPTH-1 receives INIT_VAL; busy=1; both gnt=0.
REQ-020 CLEAR -> RUN SHALL occur on the edge that writes address DEPTH-1; a sweep lasts exactly DEPTH cycles; the counter then wraps to 0.
REQ-021 RUN -> CLEAR on clr=1; no grant in that cycle.
REQ-022 clr asserted during CLEAR SHALL be ignored; the sweep does not restart.
REQ-023 In RUN, a single requester SHALL be granted in the same cycle.
REQ-024 With both requesting, round-robin: grant the port not granted most recently; after reset, A wins first.
REQ-025 An ungranted request SHALL wait without loss; worst-case wait is one cycle.
REQ-026 Write: wdata is stored at the granting edge.
REQ-027 Read: rdata and rvalid SHALL be presented on the cycle after the grant; latency 1.
REQ-028 A read granted the cycle after a write to the same address SHALL return the new data.
REQ-029 A read granted in the cycle before clr is asserted SHALL still complete its rvalid.
REQ-030 rdata SHALL hold its last value when rvalid=0.

Reset
REQ-031 On rst_n=0: state=CLEAR, counter=0, busy=1, gnt=0, rvalid=0, rdata=0, perr=0, RR pointer set to favour A.
REQ-032 Deassertion of rst_n SHALL begin a full sweep; reset during a sweep restarts it from address 0.

Configuration
REQ-033 Macro SRAM_ARB_PARITY_EN: when defined, each word stores one extra even-parity bit, and a read whose recomputed parity differs pulses perr together with rvalid.
REQ-034 Without SRAM_ARB_PARITY_EN, the array is DATA_W wide and perr is tied to 0.

Structure
REQ-035 Package sram_arb_pkg SHALL hold the state enum (CLEAR, RUN) and the default parameter constants.
REQ-036 The two-requester round-robin SHALL be sub-module rr_arb2 (req[1:0], gnt[1:0], last-grant register).

Verification
REQ-037 Reset release -> busy=1 for exactly 8192 cycles (ADDR_W=13); each address then reads 0x00.
REQ-038 A writes 0xFF to addr 0, then A reads addr 0 -> a_rvalid one cycle after grant, a_rdata=0xFF.
REQ-039 A and B request in the same cycle (A write 0xAA to 1, B read 1) -> A granted first, B next cycle, b_rdata=0xAA.
REQ-040 Both ports request continuously for 10 cycles -> grants alternate A,B,A,...; 5 each; none lost.
REQ-041 clr mid-traffic, then rst_n pulse mid-sweep -> in-flight rvalid completes; sweep restarts at 0; busy high for the full 8192 cycles after reset.
REQ-042 With SRAM_ARB_PARITY_EN, force one stored bit flipped at addr 5 and read it -> perr=1 in the rvalid cycle; without the macro, perr stays 0.
